// File: rtl/frame_check.sv
// UART receive-frame checker: assembles the data word after the start bit and
// reports parity, stop and break errors per frame with saturating error counters.
module frame_check #(
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS     = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_based_on_prescale,
    input  logic                     asy_reset,
    input  logic                     frame_start,
    input  logic                     sampled_data,
    input  logic                     sampled_data_valid,
    input  logic                     parity_enable,
    input  logic                     parity_type,
    input  logic                     err_count_clear,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     frame_done,
    output logic                     parity_error,
    output logic                     stop_error,
    output logic                     break_detect,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] parity_err_count,
    output logic [ERR_CNT_WIDTH-1:0] stop_err_count
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [3:0]               LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]               LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE   = ERR_CNT_WIDTH'(1);

    state_t                state, state_nxt;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q, par_type_q;
    logic                  run_par;
    logic                  par_err_acc;
    logic                  stop_err_acc;
    logic                  zero_acc;
    logic                  first_stop_zero;

    logic frame_end;
    logic par_err_fin, stop_err_fin, brk_fin, fsz;

    // A frame_start in the closing cycle aborts instead of completing.
    assign frame_end    = (state == STOP) && sampled_data_valid && (bit_cnt == LAST_STOP)
                          && !frame_start;
    assign fsz          = (bit_cnt == 4'd0) ? ~sampled_data : first_stop_zero;
    assign par_err_fin  = par_en_q & par_err_acc;
    assign stop_err_fin = stop_err_acc | ~sampled_data;
    assign brk_fin      = zero_acc & fsz;

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = DATA;
        end else if (sampled_data_valid) begin
            case (state)
                DATA:    if (bit_cnt == LAST_DATA) state_nxt = par_en_q ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    if (bit_cnt == LAST_STOP) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            bit_cnt <= 4'd0;
        end else if (frame_start || (state_nxt != state)) begin
            bit_cnt <= 4'd0;
        end else if (sampled_data_valid && (state != IDLE)) begin
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            shift_reg       <= '0;
            par_en_q        <= 1'b0;
            par_type_q      <= 1'b0;
            run_par         <= 1'b0;
            par_err_acc     <= 1'b0;
            stop_err_acc    <= 1'b0;
            zero_acc        <= 1'b0;
            first_stop_zero <= 1'b0;
        end else if (frame_start) begin
            shift_reg       <= '0;
            par_en_q        <= parity_enable;
            par_type_q      <= parity_type;
            run_par         <= 1'b0;
            par_err_acc     <= 1'b0;
            stop_err_acc    <= 1'b0;
            zero_acc        <= 1'b1;
            first_stop_zero <= 1'b0;
        end else if (sampled_data_valid) begin
            case (state)
                DATA: begin
                    shift_reg <= {sampled_data, shift_reg[DATA_WIDTH-1:1]};
                    run_par   <= run_par ^ sampled_data;
                    zero_acc  <= zero_acc & ~sampled_data;
                end
                PARITY: begin
                    par_err_acc <= sampled_data != (run_par ^ par_type_q);
                    zero_acc    <= zero_acc & ~sampled_data;
                end
                STOP: begin
                    if (bit_cnt == 4'd0) first_stop_zero <= ~sampled_data;
                    if (!sampled_data)   stop_err_acc    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Results are registered from the last stop sample so they line up with frame_done.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            rx_data      <= '0;
            frame_done   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            break_detect <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_start) begin
                parity_error <= 1'b0;
                stop_error   <= 1'b0;
                break_detect <= 1'b0;
            end else if (frame_end) begin
                rx_data      <= shift_reg;
                parity_error <= par_err_fin;
                stop_error   <= stop_err_fin;
                break_detect <= brk_fin;
            end
        end
    end

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            parity_err_count <= '0;
            stop_err_count   <= '0;
        end else if (err_count_clear) begin
            parity_err_count <= '0;
            stop_err_count   <= '0;
        end else if (frame_end) begin
            if (par_err_fin && (parity_err_count != CNT_MAX))
                parity_err_count <= parity_err_count + CNT_ONE;
            if (stop_err_fin && (stop_err_count != CNT_MAX))
                stop_err_count <= stop_err_count + CNT_ONE;
        end
    end

endmodule
